// File: rtl/fnd_pkg.sv
// Shared definitions for the FND display path (scan controller and decoder).
// Holds the digit geometry, the 4-digit clamp value and small digit helpers.
package fnd_pkg;

    localparam int unsigned DIGITS  = 4;
    localparam int unsigned BCD_W   = 4;
    localparam int unsigned DISP_W  = DIGITS * BCD_W;
    localparam logic [13:0] MAX_VAL = 14'd9999;

    typedef logic [1:0] digit_idx_t;

    // Pick one BCD nibble out of a packed 4-digit value
    function automatic logic [BCD_W-1:0] bcd_digit(input logic [DISP_W-1:0] bcd,
                                                   input digit_idx_t        idx);
        logic [BCD_W-1:0] nib;
        nib = '0;
        unique case (idx)
            2'd0: nib = bcd[3:0];
            2'd1: nib = bcd[7:4];
            2'd2: nib = bcd[11:8];
            2'd3: nib = bcd[15:12];
            default: nib = '0;
        endcase
        return nib;
    endfunction

    // A digit is visible if it is the ones digit or any digit at or above it is non-zero
    function automatic logic digit_visible(input logic [DISP_W-1:0] bcd,
                                           input digit_idx_t        idx);
        logic vis;
        vis = (idx == 2'd0);
        for (int i = 0; i < DIGITS; i++) begin
            if (i >= int'(idx) && bcd[i*BCD_W +: BCD_W] != '0) begin
                vis = 1'b1;
            end
        end
        return vis;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift step per clock, VAL_W steps
// per conversion. o_Done and o_Bcd are valid during the final shift cycle so the
// caller can capture the finished result on the same edge that o_Busy falls.
module bin2bcd_seq
    import fnd_pkg::*;
#(
    parameter int unsigned VAL_W = 14
) (
    input  logic              i_Clk,
    input  logic              i_Reset_n,
    input  logic              i_Start,
    input  logic [VAL_W-1:0]  i_Bin,
    output logic              o_Busy,
    output logic              o_Done,
    output logic [DISP_W-1:0] o_Bcd
);

    localparam int unsigned CNT_W = $clog2(VAL_W);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [VAL_W-1:0]    bin_q;
    logic [DISP_W-1:0]   bcd_q;
    logic [DISP_W-1:0]   bcd_adj;
    logic [DISP_W-1:0]   bcd_shift;
    logic                last_step;

    // Add-3 correction on every nibble >= 5, then shift in the next binary MSB
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[i*BCD_W +: BCD_W] >= 4'd5) begin
                bcd_adj[i*BCD_W +: BCD_W] = bcd_q[i*BCD_W +: BCD_W] + 4'd3;
            end
        end
        bcd_shift = {bcd_adj[DISP_W-2:0], bin_q[VAL_W-1]};
        last_step = (state_q == StShift) && (cnt_q == CNT_W'(VAL_W - 1));
    end

    assign o_Done = last_step;
    assign o_Bcd  = bcd_shift;

    // Conversion FSM: capture on start, shift VAL_W times, drop busy on the last shift
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            o_Busy  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_Start) begin
                        bin_q   <= i_Bin;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        o_Busy  <= 1'b1;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    bcd_q <= bcd_shift;
                    bin_q <= {bin_q[VAL_W-2:0], 1'b0};
                    cnt_q <= cnt_q + 1'b1;
                    if (last_step) begin
                        o_Busy  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Front end of the BCD-to-FND decoder: clamps and converts a binary value to four
// BCD digits, holds the result and scans it one digit per prescaled tick.
// Optional macro LEADING_ZERO_BLANK_EN blanks digits above the most significant
// non-zero digit (the ones digit always shows).
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned VAL_W    = 14
) (
    input  logic             i_Clk,
    input  logic             i_Reset_n,
    input  logic             i_Load,
    input  logic [VAL_W-1:0] i_Bin,
    input  logic             i_Enable,
    output logic             o_Busy,
    output logic             o_Overflow,
    output logic             o_En,
    output logic [1:0]       o_DigitSelect,
    output logic [BCD_W-1:0] o_Value
);

    localparam int unsigned PRE_W = $clog2(SCAN_DIV);

    logic [PRE_W-1:0]  presc_q, presc_d;
    logic              scan_tick;
    digit_idx_t        digit_q, digit_d;
    logic [DISP_W-1:0] disp_q, disp_d;
    logic              ovf_q;
    logic              en_q, en_d;
    logic [BCD_W-1:0]  value_q, value_d;
    logic              load_ok;
    logic              too_big;
    logic [VAL_W-1:0]  bin_clamped;
    logic              eng_busy;
    logic              eng_done;
    logic [DISP_W-1:0] eng_bcd;

    assign too_big     = (i_Bin > VAL_W'(MAX_VAL));
    assign bin_clamped = too_big ? VAL_W'(MAX_VAL) : i_Bin;
    assign load_ok     = i_Load && !eng_busy;

    bin2bcd_seq #(
        .VAL_W (VAL_W)
    ) u_bin2bcd (
        .i_Clk     (i_Clk),
        .i_Reset_n (i_Reset_n),
        .i_Start   (load_ok),
        .i_Bin     (bin_clamped),
        .o_Busy    (eng_busy),
        .o_Done    (eng_done),
        .o_Bcd     (eng_bcd)
    );

    // Next-state for prescaler, digit counter, display register and scan outputs
    always_comb begin
        scan_tick = (presc_q == PRE_W'(SCAN_DIV - 1));
        presc_d   = scan_tick ? '0 : presc_q + 1'b1;
        digit_d   = scan_tick ? digit_q + 2'd1 : digit_q;
        // Display only moves on completion, so a half-shifted value is never visible
        disp_d    = eng_done ? eng_bcd : disp_q;
        // Outputs are built from next-state so select, value and enable stay aligned
        value_d   = bcd_digit(disp_d, digit_d);
`ifdef LEADING_ZERO_BLANK_EN
        en_d      = i_Enable && digit_visible(disp_d, digit_d);
`else
        en_d      = i_Enable;
`endif
    end

    // Scan timing: prescaler and digit counter
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            presc_q <= '0;
            digit_q <= '0;
        end else begin
            presc_q <= presc_d;
            digit_q <= digit_d;
        end
    end

    // Display register and overflow flag
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            disp_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            disp_q <= disp_d;
            if (load_ok) begin
                ovf_q <= too_big;
            end
        end
    end

    // Registered decoder-facing outputs
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            value_q <= '0;
            en_q    <= 1'b0;
        end else begin
            value_q <= value_d;
            en_q    <= en_d;
        end
    end

    assign o_Busy        = eng_busy;
    assign o_Overflow    = ovf_q;
    assign o_En          = en_q;
    assign o_DigitSelect = digit_q;
    assign o_Value       = value_q;

endmodule
